// File: rtl/drive_seq_ctrl_if.sv
// Bus between the pulse sequencer, its drive_pc register, instruction memory and pulse sink.
// master = sequencer side, slave = environment side.
interface drive_seq_ctrl_if #(
   parameter int PC_WIDTH = 11
);
   localparam int INST_WIDTH = PC_WIDTH + 5;

   logic                  start;
   logic [PC_WIDTH-1:0]   start_addr;
   logic                  abort;
   logic [PC_WIDTH-1:0]   PC;
   logic [PC_WIDTH-1:0]   inst_addr;
   logic [INST_WIDTH-1:0] inst_data;
   logic                  update_pc;
   logic [PC_WIDTH-1:0]   next_PC;
   logic                  pulse_valid;
   logic                  pulse_ready;
   logic [PC_WIDTH+2:0]   pulse_id;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, start_addr, abort, PC, inst_data, pulse_ready,
      output inst_addr, update_pc, next_PC, pulse_valid, pulse_id, busy, done
   );

   modport slave (
      output start, start_addr, abort, PC, inst_data, pulse_ready,
      input  inst_addr, update_pc, next_PC, pulse_valid, pulse_id, busy, done
   );
endinterface

// File: rtl/drive_seq_ctrl.sv
// Pulse-program sequencer: decodes PLAY/WAIT/JUMP/HALT and steers an external PC register.
// Optional hardware repeat loop on JUMP is enabled by defining DRIVE_SEQ_LOOP_EN.
module drive_seq_ctrl #(
   parameter int PC_WIDTH = 11
) (
   input logic              clk,
   input logic              rst,
   drive_seq_ctrl_if.master bus
);
   localparam int INST_WIDTH = PC_WIDTH + 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic [1:0] OP_PLAY = 2'b00;
   localparam logic [1:0] OP_WAIT = 2'b01;
   localparam logic [1:0] OP_JUMP = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   logic [1:0]          state, state_nxt;
   logic [PC_WIDTH-1:0] wait_cnt, wait_nxt;
   logic                done_r, done_nxt;

   logic [1:0]          opcode;
   logic [PC_WIDTH-1:0] arg;
   logic [PC_WIDTH-1:0] pc_inc;

   logic                update_pc;
   logic [PC_WIDTH-1:0] next_pc;
   logic                pulse_valid;
   logic [PC_WIDTH+2:0] pulse_id;

`ifdef DRIVE_SEQ_LOOP_EN
   logic [2:0] rpt;
   logic       loop_act, loop_act_nxt;
   logic [2:0] loop_cnt, loop_cnt_nxt;

   assign rpt = bus.inst_data[PC_WIDTH+2:PC_WIDTH];
`endif

   assign opcode = bus.inst_data[INST_WIDTH-1:INST_WIDTH-2];
   assign arg    = bus.inst_data[PC_WIDTH-1:0];
   assign pc_inc = bus.PC + 1'b1;

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      done_nxt    = 1'b0;
      update_pc   = 1'b0;
      next_pc     = bus.PC;
      pulse_valid = 1'b0;
      pulse_id    = '0;
`ifdef DRIVE_SEQ_LOOP_EN
      loop_act_nxt = loop_act;
      loop_cnt_nxt = loop_cnt;
`endif
      // Reset and abort both mask every request; abort also forces IDLE.
      if (rst) begin
         state_nxt = ST_IDLE;
      end else if (bus.abort) begin
         state_nxt = ST_IDLE;
         wait_nxt  = '0;
`ifdef DRIVE_SEQ_LOOP_EN
         loop_act_nxt = 1'b0;
         loop_cnt_nxt = '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  update_pc = 1'b1;
                  next_pc   = bus.start_addr;
                  state_nxt = ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (opcode)
                  OP_PLAY: begin
                     pulse_valid = 1'b1;
                     pulse_id    = bus.inst_data[PC_WIDTH+2:0];
                     if (bus.pulse_ready) begin
                        update_pc = 1'b1;
                        next_pc   = pc_inc;
                     end
                  end
                  OP_WAIT: begin
                     if (arg == '0) begin
                        update_pc = 1'b1;
                        next_pc   = pc_inc;
                     end else begin
                        wait_nxt  = arg;
                        state_nxt = ST_WAIT;
                     end
                  end
                  OP_JUMP: begin
                     update_pc = 1'b1;
`ifdef DRIVE_SEQ_LOOP_EN
                     // loop_cnt holds the number of takes still owed after this one
                     if (rpt == 3'd0) begin
                        next_pc = arg;
                     end else if (!loop_act) begin
                        next_pc      = arg;
                        loop_act_nxt = 1'b1;
                        loop_cnt_nxt = rpt - 3'd1;
                     end else if (loop_cnt != 3'd0) begin
                        next_pc      = arg;
                        loop_cnt_nxt = loop_cnt - 3'd1;
                     end else begin
                        next_pc      = pc_inc;
                        loop_act_nxt = 1'b0;
                     end
`else
                     next_pc = arg;
`endif
                  end
                  OP_HALT: begin
                     state_nxt = ST_IDLE;
                     done_nxt  = 1'b1;
`ifdef DRIVE_SEQ_LOOP_EN
                     loop_act_nxt = 1'b0;
                     loop_cnt_nxt = '0;
`endif
                  end
                  default: ;
               endcase
            end
            ST_WAIT: begin
               // EXEC cycle plus n counted cycles gives the n+1 dwell
               wait_nxt = wait_cnt - 1'b1;
               if (wait_cnt == PC_WIDTH'(1)) begin
                  update_pc = 1'b1;
                  next_pc   = pc_inc;
                  state_nxt = ST_EXEC;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         done_r   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         done_r   <= done_nxt;
      end
   end

`ifdef DRIVE_SEQ_LOOP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loop_act <= 1'b0;
         loop_cnt <= '0;
      end else begin
         loop_act <= loop_act_nxt;
         loop_cnt <= loop_cnt_nxt;
      end
   end
`endif

   assign bus.inst_addr   = bus.PC;
   assign bus.update_pc   = update_pc;
   assign bus.next_PC     = next_pc;
   assign bus.pulse_valid = pulse_valid;
   assign bus.pulse_id    = pulse_id;
   assign bus.busy        = (state == ST_EXEC) || (state == ST_WAIT);
   assign bus.done        = done_r;
endmodule

// File: tb/tb_drive_seq_ctrl.sv
// Bench for drive_seq_ctrl: models drive_pc and instruction memory, scoreboards pulses.
module tb_drive_seq_ctrl;
   localparam int PW = 11;

   logic clk;
   logic rst;
   logic [PW-1:0] pc_q;
   logic [15:0]   mem [0:2047];

   int errs;
   int nchk;
   int done_cnt;
   int dwell [0:2047];
   logic [31:0] exp_q [$];

   drive_seq_ctrl_if #(.PC_WIDTH(PW)) bus ();

   drive_seq_ctrl #(.PC_WIDTH(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drive_pc model and async-read instruction memory
   always @(posedge clk or posedge rst)
      if (rst) pc_q <= '0;
      else if (bus.update_pc) pc_q <= bus.next_PC;

   assign bus.PC        = pc_q;
   assign bus.inst_data = mem[bus.inst_addr];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] ins(input logic [1:0] op, input logic [2:0] r, input logic [10:0] a);
      return {op, r, a};
   endfunction

   function automatic logic [31:0] pk(input logic [10:0] pc, input logic [13:0] id);
      return {7'd0, pc, id};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.done) done_cnt++;
         if (bus.busy) dwell[pc_q]++;
         if (bus.pulse_valid && bus.pulse_ready) begin
            if (exp_q.size() == 0) chk("pulse_extra", exp_q.size(), 1);
            else chk("pulse", {7'd0, pc_q, bus.pulse_id}, exp_q.pop_front());
         end
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic run_prog(input string tag, input logic [10:0] a, input int budget);
      int d0;
      int n;
      adv();
      bus.start = 1'b1;
      bus.start_addr = a;
      adv();
      bus.start = 1'b0;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         adv();
         n++;
      end
      chk({tag, "_done"}, done_cnt - d0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int d0;
      int n;
      errs = 0; nchk = 0; done_cnt = 0;
      for (int i = 0; i < 2048; i++) begin
         mem[i] = ins(2'b11, 3'd0, 11'd0);
         dwell[i] = 0;
      end
      rst = 1'b1;
      bus.start = 1'b1;
      bus.start_addr = 11'd123;
      bus.abort = 1'b0;
      bus.pulse_ready = 1'b1;

      // reset state, with start held high to confirm it is masked
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_upd", bus.update_pc, 0);
      chk("rst_pv", bus.pulse_valid, 0);
      chk("rst_pid", bus.pulse_id, 0);
      chk("rst_npc", bus.next_PC, pc_q);
      chk("rst_iaddr", bus.inst_addr, pc_q);
      bus.start = 1'b0;
      adv();
      rst = 1'b0;

      // basic launch and PLAY
      mem[5] = ins(2'b00, 3'd0, 11'd3);
      mem[6] = ins(2'b11, 3'd0, 11'd0);
      adv();
      bus.start = 1'b1;
      bus.start_addr = 11'd5;
      exp_q.push_back(pk(11'd5, 14'd3));
      @(negedge clk);
      chk("t1_upd", bus.update_pc, 1);
      chk("t1_npc", bus.next_PC, 5);
      adv();
      bus.start = 1'b0;
      @(negedge clk);
      chk("t1_pc5", pc_q, 5);
      chk("t1_pv", bus.pulse_valid, 1);
      adv();
      @(negedge clk);
      chk("t1_pc6", pc_q, 6);
      chk("t1_busy", bus.busy, 1);
      adv();
      @(negedge clk);
      chk("t1_done", bus.done, 1);
      chk("t1_idle", bus.busy, 0);
      adv();
      @(negedge clk);
      chk("t1_done_off", bus.done, 0);

      // PLAY stall with pulse_ready low; start held high must be ignored
      mem[20] = ins(2'b00, 3'd2, 11'h077);
      mem[21] = ins(2'b11, 3'd0, 11'd0);
      adv();
      bus.start = 1'b1;
      bus.start_addr = 11'd20;
      bus.pulse_ready = 1'b0;
      exp_q.push_back(pk(11'd20, 14'h1077));
      adv();
      bus.start_addr = 11'd99;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_pc_hold", pc_q, 20);
         chk("t2_pv", bus.pulse_valid, 1);
         chk("t2_pid", bus.pulse_id, 14'h1077);
         adv();
      end
      bus.pulse_ready = 1'b1;
      bus.start = 1'b0;
      adv();
      @(negedge clk);
      chk("t2_pc21", pc_q, 21);
      adv();
      @(negedge clk);
      chk("t2_done", bus.done, 1);

      // WAIT dwell times
      mem[30] = ins(2'b01, 3'd0, 11'd0);
      mem[31] = ins(2'b01, 3'd0, 11'd1);
      mem[32] = ins(2'b01, 3'd0, 11'd7);
      mem[33] = ins(2'b11, 3'd0, 11'd0);
      for (int i = 0; i < 2048; i++) dwell[i] = 0;
      run_prog("t3", 11'd30, 40);
      chk("t3_w0", dwell[30], 1);
      chk("t3_w1", dwell[31], 2);
      chk("t3_w7", dwell[32], 8);
      chk("t3_halt", dwell[33], 1);

      // PC wrap and single-cycle done
      mem[2047] = ins(2'b01, 3'd0, 11'd0);
      mem[0]    = ins(2'b11, 3'd0, 11'd0);
      adv();
      bus.start = 1'b1;
      bus.start_addr = 11'd2047;
      adv();
      bus.start = 1'b0;
      @(negedge clk);
      chk("t4_pc", pc_q, 2047);
      chk("t4_upd", bus.update_pc, 1);
      chk("t4_wrap", bus.next_PC, 0);
      adv();
      @(negedge clk);
      chk("t4_pc0", pc_q, 0);
      chk("t4_busy", bus.busy, 1);
      adv();
      @(negedge clk);
      chk("t4_done", bus.done, 1);
      chk("t4_idle", bus.busy, 0);
      adv();
      @(negedge clk);
      chk("t4_done_off", bus.done, 0);

      // abort in the middle of WAIT 7 (counter at 4)
      mem[40] = ins(2'b01, 3'd0, 11'd7);
      mem[41] = ins(2'b11, 3'd0, 11'd0);
      d0 = done_cnt;
      adv();
      bus.start = 1'b1;
      bus.start_addr = 11'd40;
      adv();
      bus.start = 1'b0;
      repeat (4) adv();
      bus.abort = 1'b1;
      @(negedge clk);
      chk("t5_upd", bus.update_pc, 0);
      chk("t5_pv", bus.pulse_valid, 0);
      chk("t5_busy_pre", bus.busy, 1);
      adv();
      bus.abort = 1'b0;
      @(negedge clk);
      chk("t5_idle", bus.busy, 0);
      chk("t5_pc", pc_q, 40);
      repeat (2) adv();
      chk("t5_no_done", done_cnt - d0, 0);
      // abort beats start in IDLE
      bus.start = 1'b1;
      bus.abort = 1'b1;
      bus.start_addr = 11'd5;
      @(negedge clk);
      chk("t5_prio_upd", bus.update_pc, 0);
      adv();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge clk);
      chk("t5_prio_idle", bus.busy, 0);
      exp_q.push_back(pk(11'd5, 14'd3));
      run_prog("t5_restart", 11'd5, 10);
      chk("t5_sbq", exp_q.size(), 0);

      // JUMP repeat loop
      mem[10] = ins(2'b00, 3'd1, 11'd5);
      mem[11] = ins(2'b10, 3'd3, 11'd10);
      mem[12] = ins(2'b11, 3'd0, 11'd0);
`ifdef DRIVE_SEQ_LOOP_EN
      for (int i = 0; i < 4; i++) exp_q.push_back(pk(11'd10, {3'd1, 11'd5}));
      run_prog("t6", 11'd10, 40);
      chk("t6_pc", pc_q, 12);
      chk("t6_sbq", exp_q.size(), 0);
`else
      for (int i = 0; i < 10; i++) exp_q.push_back(pk(11'd10, {3'd1, 11'd5}));
      d0 = done_cnt;
      adv();
      bus.start = 1'b1;
      bus.start_addr = 11'd10;
      adv();
      bus.start = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         adv();
         n++;
      end
      chk("t6_sbq", exp_q.size(), 0);
      chk("t6_pc_jump", pc_q, 11);
      bus.abort = 1'b1;
      @(negedge clk);
      chk("t6_pv", bus.pulse_valid, 0);
      adv();
      bus.abort = 1'b0;
      @(negedge clk);
      chk("t6_idle", bus.busy, 0);
      chk("t6_no_done", done_cnt - d0, 0);
`endif

      repeat (2) adv();
      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end
endmodule

// File: doc/drive_seq_ctrl.md
DRIVE_SEQ_CTRL -- requirements
Module: drive_seq_ctrl

Interface
REQ-001 The parameter PC_WIDTH SHALL default to 11 and set the program counter width; localparam INST_WIDTH SHALL equal PC_WIDTH+5.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit, the asynchronous active-high reset.
REQ-004 Port start SHALL be an input, 1 bit, a program launch request honoured only in IDLE.
REQ-005 Port start_addr SHALL be an input, PC_WIDTH bits, the program entry address.
REQ-006 Port abort SHALL be an input, 1 bit, a synchronous program kill.
REQ-007 Port PC SHALL be an input, PC_WIDTH bits, the current program counter from drive_pc.
REQ-008 Port inst_addr SHALL be an output, PC_WIDTH bits, the instruction memory address.
REQ-009 Port inst_data SHALL be an input, INST_WIDTH bits, the asynchronous-read instruction word.
REQ-010 Port update_pc SHALL be an output, 1 bit, the load enable to drive_pc.
REQ-011 Port next_PC SHALL be an output, PC_WIDTH bits, the value drive_pc loads.
REQ-012 Port pulse_valid SHALL be an output, 1 bit, a pulse request; port pulse_ready SHALL be an input, 1 bit, the pulse acceptance.
REQ-013 Port pulse_id SHALL be an output, PC_WIDTH+3 bits, the pulse identifier.
REQ-014 Ports busy and done SHALL be outputs, 1 bit each: program running, and a 1-cycle completion strobe.

Function
REQ-015 inst_addr SHALL equal PC combinationally; inst_data SHALL be decoded in the same cycle.
REQ-016 Decode: opcode = inst_data[INST_WIDTH-1:INST_WIDTH-2]; 00 PLAY, 01 WAIT, 10 JUMP, 11 HALT; arg = inst_data[PC_WIDTH-1:0]; R = inst_data[PC_WIDTH+2:PC_WIDTH].
REQ-017 The FSM SHALL have states IDLE, EXEC and WAIT; busy SHALL be 1 in EXEC and WAIT only.
REQ-018 In IDLE with start=1: update_pc=1, next_PC=start_addr, go to EXEC; start SHALL be ignored outside IDLE.
REQ-019 PLAY in EXEC: pulse_valid=1, pulse_id=inst_data[PC_WIDTH+2:0]; only when pulse_ready=1 SHALL update_pc=1, next_PC=PC+1; otherwise stall with PC held.
REQ-020 WAIT n: the instruction SHALL occupy exactly n+1 cycles; n=0 advances in EXEC; n>0 loads the counter with n, enters WAIT, and decrements it each cycle; update_pc=1 with next_PC=PC+1 when the counter equals 1, then return to EXEC.
REQ-021 JUMP: update_pc=1, next_PC=arg (see REQ-029 when the macro is defined).
REQ-022 HALT: update_pc=0, go to IDLE, and assert done (registered) for exactly the next cycle.
REQ-023 PC+1 SHALL wrap modulo 2^PC_WIDTH (2047 -> 0).
REQ-024 abort=1 in any state SHALL force IDLE next cycle with update_pc=0 and pulse_valid=0 in the abort cycle; abort SHALL take priority over decode and start; done SHALL NOT be asserted.
REQ-025 In IDLE, update_pc, pulse_valid and busy SHALL be 0 except per REQ-018; next_PC SHALL be PC when update_pc=0.

Reset
REQ-026 When rst=1, the block SHALL be in IDLE with the wait counter at 0, the loop state cleared, and done=0, independent of clk.
REQ-027 Reset values SHALL be: update_pc=0, pulse_valid=0, busy=0, done=0, pulse_id=0, next_PC=PC, inst_addr=PC.

Configuration
REQ-028 The macro DRIVE_SEQ_LOOP_EN SHALL gate the hardware repeat loop; when it is undefined, JUMP SHALL be unconditional, R SHALL be ignored, and no loop registers SHALL exist.
REQ-029 When DRIVE_SEQ_LOOP_EN is defined:
- JUMP with R=0 SHALL be unconditional.
- JUMP with R>0 SHALL be taken exactly R times, then fall through to PC+1 and clear the loop state.
- Only one loop level SHALL be supported.
- abort and HALT SHALL clear the loop state.

Verification
REQ-030 start=1, start_addr=5, mem[5]=PLAY id 3, pulse_ready=1 -> update_pc=1 with next_PC=5 in the start cycle; pulse_valid=1 with pulse_id=3 at PC=5; PC=6 next cycle.
REQ-031 PLAY with pulse_ready held at 0 for 4 cycles -> PC held for 4 cycles and pulse_valid steady; PC advances on the cycle pulse_ready=1.
REQ-032 WAIT 0, WAIT 1 and WAIT 7 in sequence -> PC dwells 1, 2 and 8 cycles respectively.
REQ-033 mem[2047]=WAIT 0 -> next_PC=0; mem[0]=HALT -> done=1 for exactly one cycle, then busy=0.
REQ-034 abort during WAIT 7 at count 4 -> IDLE next cycle, done stays 0; a later start restarts cleanly.
REQ-035 With DRIVE_SEQ_LOOP_EN defined, PLAY at address 10 and JUMP R=3 target 10 at address 11 -> 4 pulses, then PC=12; without the macro -> endless pulses.
